// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-state and arbiter types.
// Used by mem_arbiter and its interface.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    ISRV,
    DSRV
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int ARB_STARVE_DEFAULT = 4;

  function automatic arb_owner_t owner_of(arb_state_t s);
    arb_owner_t o;
    case (s)
      ISRV:    o = OWN_I;
      DSRV:    o = OWN_D;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side requests plus the RAM port.
// slave = arbiter view, master = requester/RAM-model view.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload,
    output ramREN, ramWEN, ramaddr, ramstore,
    output ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    input  ram_err
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of back-to-back D grants
// taken while an I request waits.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !sat)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between I-fetch and data.
// Optional perf counters when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_DEFAULT
`ifdef MEM_ARB_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  , output logic [CNT_W-1:0] perf_igrant
  , output logic [CNT_W-1:0] perf_dgrant
  , output logic [CNT_W-1:0] perf_stall
`endif
);

  arb_state_t state_q, state_d, cur;
  arb_owner_t owner;

  logic  dreq;
  logic  i_done, d_done, beat_err;
  logic  ram_err_q, ram_err_d;
  logic  sat;
  logic  ren, wen;
  logic  iwait, dwait;
  word_t addr, store;

  // Reset aborts at once: the current cycle already looks idle.
  always_comb begin
    dreq      = bus.dREN | bus.dWEN;
    cur       = RST ? IDLE : state_q;
    owner     = owner_of(cur);
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    store     = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    beat_err  = 1'b0;
    state_d   = state_q;
    unique case (owner)
      OWN_I: begin
        if (bus.iREN) begin
          ren      = 1'b1;
          addr     = bus.iaddr;
          i_done   = (bus.ramstate == ACCESS);
          beat_err = (bus.ramstate == ERROR);
        end
        if (!bus.iREN || i_done || beat_err)
          state_d = IDLE;
      end
      OWN_D: begin
        if (dreq) begin
          wen      = bus.dWEN;
          ren      = bus.dREN & ~bus.dWEN;
          addr     = bus.daddr;
          store    = bus.dstore;
          d_done   = (bus.ramstate == ACCESS);
          beat_err = (bus.ramstate == ERROR);
        end
        if (!dreq || d_done || beat_err)
          state_d = IDLE;
      end
      default: begin
        if (dreq && !(bus.iREN && sat))
          state_d = DSRV;
        else if (bus.iREN)
          state_d = ISRV;
        else
          state_d = IDLE;
      end
    endcase
    ram_err_d = ram_err_q | beat_err;
  end

  assign iwait = bus.iREN & ~i_done;
  assign dwait = dreq & ~d_done;

  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.ram_err  = ram_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_err_q <= ram_err_d;
    end
  end

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk(CLK),
    .rst(RST),
    .inc(d_done & bus.iREN),
    .clr(i_done | (d_done & ~bus.iREN)),
    .sat(sat)
  );

`ifdef MEM_ARB_PERF_EN
  logic             stall;
  logic [CNT_W-1:0] perf_igrant_q, perf_igrant_d;
  logic [CNT_W-1:0] perf_dgrant_q, perf_dgrant_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    stall         = (bus.iREN & iwait) | (dreq & dwait);
    perf_igrant_d = perf_igrant_q + CNT_W'(i_done);
    perf_dgrant_d = perf_dgrant_q + CNT_W'(d_done);
    perf_stall_d  = perf_stall_q + CNT_W'(stall);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_igrant_q <= '0;
      perf_dgrant_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_igrant_q <= perf_igrant_d;
      perf_dgrant_q <= perf_dgrant_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_igrant = perf_igrant_q;
  assign perf_dgrant = perf_dgrant_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
